// File: rtl/rect_motion_ctl.sv
// Player rectangle motion controller: per-frame horizontal walk plus a
// jump/gravity state machine against the ground line.
module rect_motion_ctl #(
    parameter int X_INIT   = 100,
    parameter int Y_INIT   = 300,
    parameter int GROUND_Y = 470,
    parameter int X_MAX    = 1230,
    parameter int STEP_X   = 4,
    parameter int JUMP_V   = 16,
    parameter int GRAVITY  = 1,
    parameter int V_MAX    = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        on_ground
);

    typedef enum logic [1:0] {
        GROUND,
        RISE,
        FALL
    } state_t;

    localparam logic [11:0] GY = 12'(GROUND_Y);
    localparam logic [11:0] XM = 12'(X_MAX);
    localparam logic [11:0] SX = 12'(STEP_X);
    localparam logic [11:0] XI = 12'(X_INIT);
    localparam logic [11:0] YI = 12'(Y_INIT);
    localparam logic [5:0]  JV = 6'(JUMP_V);
    localparam logic [5:0]  GR = 6'(GRAVITY);
    localparam logic [5:0]  VM = 6'(V_MAX);

    state_t      state_q, state_d;
    logic        vblnk_d_q;
    logic        tick;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [5:0]  vel_q, vel_d;
    logic        og_q, og_d;

    logic [6:0]  v_inc;
    logic [5:0]  v_fall;
    logic [12:0] y_sum;
    logic [12:0] x_sum;

    assign tick = vblnk & ~vblnk_d_q;

    // Fall speed saturates at terminal velocity; sums are one bit wider
    // so the ground and right-edge compares cannot wrap.
    assign v_inc  = {1'b0, vel_q} + {1'b0, GR};
    assign v_fall = (v_inc > {1'b0, VM}) ? VM : v_inc[5:0];
    assign y_sum  = {1'b0, y_q} + {7'd0, v_fall};
    assign x_sum  = {1'b0, x_q} + {1'b0, SX};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vel_d   = vel_q;
        og_d    = og_q;
        if (tick) begin
            unique case (state_q)
                GROUND: begin
                    if (btn_jump) begin
                        state_d = RISE;
                        vel_d   = JV;
                    end
                end
                RISE: begin
                    if (y_q < {6'd0, vel_q}) begin
                        y_d     = 12'd0;
                        vel_d   = 6'd0;
                        state_d = FALL;
                    end else if (vel_q <= GR) begin
                        y_d     = y_q - {6'd0, vel_q};
                        vel_d   = 6'd0;
                        state_d = FALL;
                    end else begin
                        y_d   = y_q - {6'd0, vel_q};
                        vel_d = vel_q - GR;
                    end
                end
                FALL: begin
                    if (y_sum >= {1'b0, GY}) begin
                        y_d     = GY;
                        vel_d   = 6'd0;
                        state_d = GROUND;
                    end else begin
                        y_d   = y_sum[11:0];
                        vel_d = v_fall;
                    end
                end
                default: state_d = FALL;
            endcase

            if (btn_left && !btn_right) begin
                x_d = (x_q < SX) ? 12'd0 : x_q - SX;
            end else if (btn_right && !btn_left) begin
                x_d = (x_sum > {1'b0, XM}) ? XM : x_sum[11:0];
            end

            og_d = (state_d == GROUND);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FALL;
            vblnk_d_q <= 1'b0;
            x_q       <= XI;
            y_q       <= YI;
            vel_q     <= 6'd0;
            og_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            vblnk_d_q <= vblnk;
            x_q       <= x_d;
            y_q       <= y_d;
            vel_q     <= vel_d;
            og_q      <= og_d;
        end
    end

    assign xpos      = x_q;
    assign ypos      = y_q;
    assign on_ground = og_q;

endmodule
